// File: rtl/lif_neuron_array.sv
// lif_neuron_array: N leaky integrate-and-fire neurons behind one shared, time-multiplexed datapath.
// Per-neuron saturating spike counters are built only when LIF_SPIKE_COUNT_EN is defined.
module lif_neuron_array #(
    parameter int unsigned N_NEURONS     = 16,
    parameter int unsigned POT_W         = 16,
    parameter int unsigned IN_W          = 16,
    parameter int          THRESHOLD     = 16'h0960,
    parameter int unsigned LEAK_SHIFT    = 4,
    parameter int unsigned REFRACT_STEPS = 8,
    parameter int unsigned CNT_W         = 8,
    localparam int unsigned IDX_W        = $clog2(N_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IDX_W-1:0]       in_idx,
    input  logic signed [IN_W-1:0] in_weight,
    input  logic                   step,
    output logic                   out_valid,
    output logic [N_NEURONS-1:0]   out_spike,
    output logic                   err_idx,
    output logic                   err_overrun,
    input  logic [IDX_W-1:0]       cnt_idx,
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       cnt_data
);

    localparam int unsigned RW = $clog2(REFRACT_STEPS + 1);
    localparam logic [IDX_W:0]   N_LIM     = (IDX_W + 1)'(N_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_NEURONS - 1);
    localparam logic [RW-1:0]    REFR_INIT = RW'(REFRACT_STEPS);
    localparam logic signed [POT_W-1:0] THR     = POT_W'(THRESHOLD);
    localparam logic signed [POT_W-1:0] POT_MAX = {1'b0, {(POT_W - 1){1'b1}}};
    localparam logic signed [POT_W-1:0] POT_MIN = {1'b1, {(POT_W - 1){1'b0}}};

    typedef enum logic [1:0] {StAccum, StSweep, StDone} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        sweep_idx_q;
    logic signed [POT_W-1:0] pot_q [N_NEURONS];
    logic [RW-1:0]           refr_q [N_NEURONS];
    logic [N_NEURONS-1:0]    shadow_q, shadow_d;
    logic [N_NEURONS-1:0]    out_spike_q;
    logic                    err_idx_q, err_overrun_q;

    logic                    in_sweep, sweep_en, step_take, ev_fire, idx_ok, ev_apply, fire;
    logic [IDX_W-1:0]        sel;
    logic signed [POT_W-1:0] cur_pot, leaked, sat_pot, pot_wd;
    logic [RW-1:0]           cur_refr, refr_wd;
    logic signed [POT_W:0]   sum;
    logic                    pot_we, refr_we;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAccum;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; en low freezes the sequencer in place
    always_comb begin
        state_d = state_q;
        if (en) begin
            unique case (state_q)
                StAccum: if (step) state_d = StSweep;
                StSweep: if (sweep_idx_q == LAST_IDX) state_d = StDone;
                StDone:  state_d = StAccum;
                default: state_d = StAccum;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        in_ready  = en && (state_q != StSweep);
        out_valid = en && (state_q == StDone);
        in_sweep  = (state_q == StSweep);
        sweep_en  = en && in_sweep;
        step_take = en && step && (state_q == StAccum);
    end

    // Shared datapath: the sweep owns the neuron port during SWEEP, the event path otherwise
    always_comb begin
        sel      = in_sweep ? sweep_idx_q : in_idx;
        cur_pot  = pot_q[sel];
        cur_refr = refr_q[sel];
        ev_fire  = in_valid && in_ready;
        idx_ok   = ({1'b0, in_idx} < N_LIM);
        ev_apply = ev_fire && idx_ok && (cur_refr == '0);

        sum = {cur_pot[POT_W-1], cur_pot} + (POT_W + 1)'(in_weight);
        if (sum[POT_W] != sum[POT_W-1]) begin
            sat_pot = sum[POT_W] ? POT_MIN : POT_MAX;
        end else begin
            sat_pot = sum[POT_W-1:0];
        end

        leaked = cur_pot - (cur_pot >>> LEAK_SHIFT);
        fire   = sweep_en && (cur_refr == '0) && (leaked >= THR);

        pot_we  = 1'b0;
        pot_wd  = sat_pot;
        refr_we = 1'b0;
        refr_wd = '0;
        if (ev_apply) begin
            pot_we = 1'b1;
        end
        if (sweep_en) begin
            if (cur_refr != '0) begin
                refr_we = 1'b1;
                refr_wd = cur_refr - RW'(1);
            end else if (fire) begin
                pot_we  = 1'b1;
                pot_wd  = '0;
                refr_we = 1'b1;
                refr_wd = REFR_INIT;
            end else begin
                pot_we = 1'b1;
                pot_wd = leaked;
            end
        end

        shadow_d = shadow_q;
        if (sweep_en) begin
            shadow_d[sweep_idx_q] = fire;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_NEURONS); i++) begin
                pot_q[i]  <= '0;
                refr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_NEURONS); i++) begin
                if (pot_we && (sel == IDX_W'(i))) pot_q[i] <= pot_wd;
                if (refr_we && (sel == IDX_W'(i))) refr_q[i] <= refr_wd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_idx_q   <= '0;
            shadow_q      <= '0;
            out_spike_q   <= '0;
            err_idx_q     <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            if (step_take) begin
                sweep_idx_q <= '0;
            end else if (sweep_en) begin
                sweep_idx_q <= sweep_idx_q + IDX_W'(1);
            end
            if (sweep_en) begin
                shadow_q <= shadow_d;
                if (sweep_idx_q == LAST_IDX) out_spike_q <= shadow_d;
            end
            if (ev_fire && !idx_ok) err_idx_q <= 1'b1;
            if (en && step && (state_q != StAccum)) err_overrun_q <= 1'b1;
        end
    end

    assign out_spike   = out_spike_q;
    assign err_idx     = err_idx_q;
    assign err_overrun = err_overrun_q;

`ifdef LIF_SPIKE_COUNT_EN
    logic [CNT_W-1:0] cnt_q [N_NEURONS];
    logic [CNT_W-1:0] cnt_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_NEURONS); i++) cnt_q[i] <= '0;
            cnt_data_q <= '0;
        end else if (en) begin
            for (int i = 0; i < int'(N_NEURONS); i++) begin
                if (cnt_clr) begin
                    cnt_q[i] <= '0;
                end else if (fire && (sweep_idx_q == IDX_W'(i)) && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
            cnt_data_q <= ({1'b0, cnt_idx} < N_LIM) ? cnt_q[cnt_idx] : '0;
        end
    end

    assign cnt_data = cnt_data_q;
`else
    logic unused_cnt;
    assign unused_cnt = ^{cnt_idx, cnt_clr};
    assign cnt_data   = '0;
`endif

endmodule

// File: tb/tb_lif_neuron_array.sv
// tb_lif_neuron_array: directed and randomized checks against a transaction-level neuron model.
// Counter expectations follow LIF_SPIKE_COUNT_EN when the bench is built with it.
module tb_lif_neuron_array;

    localparam int N    = 12;
    localparam int TH   = 2400;
    localparam int LS   = 4;
    localparam int RS   = 3;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic               clk, rst_n, en, in_valid, in_ready, step;
    logic [3:0]         in_idx, cnt_idx;
    logic signed [15:0] in_weight;
    logic               out_valid, err_idx, err_overrun, cnt_clr;
    logic [N-1:0]       out_spike;
    logic [CW-1:0]      cnt_data;

    lif_neuron_array #(
        .N_NEURONS(N), .POT_W(16), .IN_W(16), .THRESHOLD(TH), .LEAK_SHIFT(LS),
        .REFRACT_STEPS(RS), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .in_idx(in_idx), .in_weight(in_weight), .step(step), .out_valid(out_valid),
        .out_spike(out_spike), .err_idx(err_idx), .err_overrun(err_overrun),
        .cnt_idx(cnt_idx), .cnt_clr(cnt_clr), .cnt_data(cnt_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: neuron state plus a coarse busy/done view of the sweep
    int           pot [N];
    int           refr [N];
    int           cnt [N];
    int           busy;
    bit           done;
    logic [N-1:0] exp_spike, pend_spike;
    bit           exp_err_idx, exp_err_ovr, cnt_known;
    int           exp_cnt_data;
    int           cur_cidx = 0;

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            pot[i] = 0; refr[i] = 0; cnt[i] = 0;
        end
        busy = 0; done = 0; exp_spike = '0; pend_spike = '0;
        exp_err_idx = 0; exp_err_ovr = 0; cnt_known = 1; exp_cnt_data = 0;
    endtask

    // Whole timestep applied at once
    task automatic model_sweep();
        for (int i = 0; i < N; i++) begin
            int lk;
            pend_spike[i] = 1'b0;
            if (refr[i] != 0) begin
                refr[i]--;
            end else begin
                lk = pot[i] - (pot[i] >>> LS);
                if (lk >= TH) begin
                    pend_spike[i] = 1'b1;
                    pot[i] = 0;
                    refr[i] = RS;
                    if (cnt[i] < CMAX) cnt[i]++;
                end else begin
                    pot[i] = lk;
                end
            end
        end
    endtask

    // One clock cycle: drive, check current outputs, update model, take the edge
    task automatic cyc(input bit v, input int idx, input int w, input bit st, input bit e,
                       input bit clr);
        bit rdy;
        in_valid = v; in_idx = 4'(idx); in_weight = 16'(w); step = st; en = e;
        cnt_clr = clr; cnt_idx = 4'(cur_cidx);
        #1;
        rdy = e && (busy == 0);
        chk("in_ready", in_ready, rdy);
        chk("out_valid", out_valid, e && done);
        chk("out_spike", out_spike, exp_spike);
        chk("err_idx", err_idx, exp_err_idx);
        chk("err_overrun", err_overrun, exp_err_ovr);
        if (cnt_known) chk("cnt_data", cnt_data, exp_cnt_data);
        if (e) begin
`ifdef LIF_SPIKE_COUNT_EN
            exp_cnt_data = cnt[cur_cidx];
            cnt_known = (busy == 0);
            if (clr) for (int i = 0; i < N; i++) cnt[i] = 0;
`else
            exp_cnt_data = 0;
            cnt_known = 1;
`endif
            if (v && rdy) begin
                if (idx >= N) exp_err_idx = 1;
                else if (refr[idx] == 0) pot[idx] = sat16(pot[idx] + w);
            end
            if (done) begin
                done = 0;
                if (st) exp_err_ovr = 1;
            end else if (busy > 0) begin
                if (st) exp_err_ovr = 1;
                busy--;
                if (busy == 0) begin
                    done = 1;
                    exp_spike = pend_spike;
                end
            end else if (st) begin
                model_sweep();
                busy = N;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 1, 0);
    endtask

    // Wait for the result pulse after a step, then leave DONE
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            idle();
            lat++;
        end
        if (!out_valid) chk("timeout", 0, 1);
        idle();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_spike", out_spike, 0);
        chk("rst_err_idx", err_idx, 0);
        chk("rst_err_overrun", err_overrun, 0);
        chk("rst_cnt_data", cnt_data, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    int lat, pulses;
    logic signed [15:0] rw;

    initial begin
        rst_n = 1'b0; en = 0; in_valid = 0; in_idx = 0; in_weight = 0; step = 0;
        cnt_clr = 0; cnt_idx = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // Fire neuron 3 and measure step-to-result latency
        cyc(1, 3, 'h0A00, 0, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        wait_done(lat);
        chk("fire_latency", lat, N + 1);
        chk("fire_vector", out_spike, 12'h008);

        // Refractory: inputs discarded for RS steps, then fires again
        for (int s = 0; s < RS; s++) begin
            cyc(1, 3, 5000, 0, 1, 0);
            cyc(0, 0, 0, 1, 1, 0);
            wait_done(lat);
            chk("refr_silent", out_spike[3], 0);
        end
        cyc(1, 3, 'h0A00, 0, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        wait_done(lat);
        chk("refr_refire", out_spike[3], 1);
        repeat (RS) begin
            cyc(0, 0, 0, 1, 1, 0);
            wait_done(lat);
        end

        // Just below threshold after leak: 2550 -> 2391
        cyc(1, 3, 'h09F6, 0, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        wait_done(lat);
        chk("subthresh", out_spike[3], 0);

        // Saturation both ways
        repeat (4) cyc(1, 0, 'h7000, 0, 1, 0);
        repeat (2) cyc(1, 1, -'h7000, 0, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        wait_done(lat);
        chk("sat_pos_fire", out_spike[0], 1);
        chk("sat_neg_silent", out_spike[1], 0);

        // Out-of-range index
        cyc(1, 13, 'h0A00, 0, 1, 0);
        chk("err_idx_set", err_idx, 1);

        // Event in the step cycle is included in that sweep
        cyc(1, 7, 'h0A00, 1, 1, 0);
        wait_done(lat);
        chk("step_event", out_spike[7], 1);

        // Overrun: second step mid-sweep yields one result only
        cyc(0, 0, 0, 1, 1, 0);
        idle();
        cyc(0, 0, 0, 1, 1, 0);
        pulses = 0;
        for (int k = 0; k < 2 * N; k++) begin
            idle();
            if (out_valid) pulses++;
        end
        chk("overrun_flag", err_overrun, 1);
        chk("overrun_pulses", pulses, 1);

        // en low for 5 cycles mid-sweep delays the result by 5
        cyc(0, 0, 0, 1, 1, 0);
        lat = 1;
        while (!out_valid && lat < 60) begin
            cyc(0, 0, 0, 0, !(lat >= 4 && lat < 9), 0);
            lat++;
        end
        chk("freeze_latency", lat, N + 6);
        idle();

        // Counter saturation on neuron 5, then clear
        cur_cidx = 5;
        cyc(0, 0, 0, 0, 1, 1);
        repeat (CMAX + 3) begin
            cyc(1, 5, 'h0A00, 1, 1, 0);
            wait_done(lat);
            repeat (RS) begin
                cyc(0, 0, 0, 1, 1, 0);
                wait_done(lat);
            end
        end
        idle();
`ifdef LIF_SPIKE_COUNT_EN
        chk("cnt_sat", cnt_data, CMAX);
`else
        chk("cnt_sat", cnt_data, 0);
`endif
        cyc(0, 0, 0, 0, 1, 1);
        idle();
        chk("cnt_clr", cnt_data, 0);

        // Randomized traffic with one mid-run reset
        for (int i = 0; i < 2500; i++) begin
            bit e, v, st, clr;
            int idx, w;
            if (i == 1200) do_reset();
            e   = ($urandom_range(0, 9) != 0);
            v   = ($urandom_range(0, 1) == 1);
            idx = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) begin
                rw = 16'($urandom);
                w  = rw;
            end else begin
                w = $urandom_range(0, 1200);
            end
            st  = ($urandom_range(0, 19) == 0);
            clr = (busy == 0) && ($urandom_range(0, 99) == 0);
            cur_cidx = $urandom_range(0, N - 1);
            cyc(v, idx, w, st, e, clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
